div_unit: RTL and testbench

// Multi-cycle RV32M divide/remainder unit in the execute stage, directly downstream of the register file.

---
 rtl/div_unit.sv | 151 +++++++++++++++
 tb/tb_div_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle RV32M divide/remainder unit (restoring radix-2,
// one quotient bit per cycle). Holds busy until the result is presented
// with a one-cycle ready pulse.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    output logic            busy,
    output logic            ready,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   LAST_STEP = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_VAL   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          state;
    logic [1:0]      op_r;
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] dvd;
    logic [XLEN-1:0] dvs;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [CW-1:0]   cnt;

    logic            is_signed;
    logic            sign1;
    logic            sign2;
    logic [XLEN-1:0] abs1;
    logic [XLEN-1:0] abs2;
    logic            div_zero;
    logic            overflow;

    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic            ge;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quo_nx;
    logic [XLEN-1:0] final_val;
    logic            final_neg;
    logic [XLEN-1:0] final_res;

    // Operand preparation: magnitudes, sign flags and special-case detection
    always_comb begin
        is_signed = ~op[0];
        sign1     = is_signed & rdata1[XLEN-1];
        sign2     = is_signed & rdata2[XLEN-1];
        abs1      = sign1 ? ('0 - rdata1) : rdata1;
        abs2      = sign2 ? ('0 - rdata2) : rdata2;
        div_zero  = (rdata2 == '0);
        overflow  = is_signed && (rdata1 == MIN_VAL) && (rdata2 == '1);
    end

    // One restoring step; the partial remainder keeps the bit shifted out of
    // its MSB so the compare against the divisor is done on XLEN+1 bits
    always_comb begin
        rem_sh    = {rem, dvd[XLEN-1]};
        diff      = rem_sh - {1'b0, dvs};
        ge        = ~diff[XLEN];
        rem_nx    = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_nx    = {quo[XLEN-2:0], ge};
        final_val = op_r[1] ? rem_nx : quo_nx;
        final_neg = ~op_r[0] & (op_r[1] ? neg_r : neg_q);
        final_res = final_neg ? ('0 - final_val) : final_val;
    end

    // Control FSM and datapath registers; flush/reset override everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            op_r   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            quo    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            ready  <= 1'b0;
            result <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            ready <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ready <= 1'b0;
                    if (start) begin
                        op_r <= op;
                        busy <= 1'b1;
                        if (div_zero) begin
                            result <= op[1] ? rdata1 : '1;
                            ready  <= 1'b1;
                            state  <= S_DONE;
                        end else if (overflow) begin
                            result <= op[1] ? '0 : MIN_VAL;
                            ready  <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            dvd   <= abs1;
                            dvs   <= abs2;
                            rem   <= '0;
                            quo   <= '0;
                            cnt   <= '0;
                            neg_q <= sign1 ^ sign2;
                            neg_r <= sign1;
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    dvd <= {dvd[XLEN-2:0], 1'b0};
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST_STEP) begin
                        result <= final_res;
                        ready  <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    ready <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checks of div_unit against an
// arithmetic reference model of RV32M DIV/DIVU/REM/REMU.
module tb_div_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            flush;
    logic [1:0]      op;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic            busy;
    logic            ready;
    logic [XLEN-1:0] result;

    int checks = 0;
    int errors = 0;

    div_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .op     (op),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .busy   (busy),
        .ready  (ready),
        .result (result)
    );

    always #5 clk = ~clk;

    // Reference result from plain RISC-V arithmetic rules
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!o[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = 32'($signed(a) / $signed(b));
                r = 32'($signed(a) % $signed(b));
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return o[1] ? r : q;
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    // Called at a negedge (cycle 0); returns at the negedge of the cycle after ready
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit noise, input string name);
        logic [31:0] exp_res;
        logic [31:0] got;
        int lat;
        int rdy_cnt;
        int rdy_cyc;
        int busy_bad;
        exp_res  = model(o, a, b);
        lat      = model_lat(o, a, b);
        op       = o;
        rdata1   = a;
        rdata2   = b;
        start    = 1'b1;
        rdy_cnt  = 0;
        rdy_cyc  = -1;
        busy_bad = 0;
        got      = '0;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (noise) begin
                rdata1 = $urandom;
                rdata2 = $urandom;
                op     = 2'($urandom);
                if (k <= lat) start = 1'($urandom_range(0, 1));
            end
            if (ready === 1'b1) begin
                rdy_cnt++;
                rdy_cyc = k;
                got     = result;
            end
            if (busy !== (k <= lat)) busy_bad++;
        end
        checks++;
        if (got !== exp_res) begin
            errors++;
            $display("FAIL %s result: got %h expected %h (op %b a %h b %h)", name, got, exp_res, o, a, b);
        end
        checks++;
        if (rdy_cnt !== 1 || rdy_cyc !== lat) begin
            errors++;
            $display("FAIL %s ready: pulses %0d at cycle %0d expected 1 at cycle %0d", name, rdy_cnt, rdy_cyc, lat);
        end
        checks++;
        if (busy_bad !== 0) begin
            errors++;
            $display("FAIL %s busy: %0d wrong cycles expected 0", name, busy_bad);
        end
        for (int i = 0; i < 60 && busy === 1'b1; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; rdata1 = '0; rdata2 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy %b ready %b result %h expected 0 0 0", busy, ready, result);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op(2'b01, 32'd100, 32'd7, 1'b0, "divu_100_7");
        run_op(2'b11, 32'd100, 32'd7, 1'b0, "remu_100_7");
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, "rem_m7_2");
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, "remu_big_2");
        run_op(2'b01, 32'd5, 32'd0, 1'b0, "divu_by_zero");
        run_op(2'b10, 32'd5, 32'd0, 1'b0, "rem_by_zero");
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem_overflow");
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "divu_max");
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "remu_max");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  o;
        for (int n = 0; n < 60; n++) begin
            o = 2'($urandom);
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'($urandom_range(1, 15));
                1: b = 32'd0;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = 32'h0 - 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_op(o, a, b, 1'b1, "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++)
            run_op(2'($urandom), $urandom, 32'($urandom_range(1, 1000)), 1'b0, "back_to_back");
    endtask

    task automatic test_flush();
        int seen;
        op = 2'b01; rdata1 = 32'd1000; rdata2 = 32'd3; start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 10) flush = 1'b1;
        end
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_mid: busy %b ready %b expected 0 0", busy, ready);
        end
        @(negedge clk);
        run_op(2'b01, $urandom, 32'($urandom_range(1, 1000)), 1'b0, "after_flush");
        op = 2'b01; rdata1 = 32'd5; rdata2 = 32'd0; start = 1'b1; flush = 1'b1;
        seen = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0; flush = 1'b0;
            if (busy !== 1'b0 || ready !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL flush_with_start: %0d active cycles expected 0", seen);
        end
    endtask

    task automatic test_rst_mid();
        run_op(2'b01, 32'd100, 32'd7, 1'b0, "pre_rst");
        op = 2'b00; rdata1 = $urandom; rdata2 = 32'd7; start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 20) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid: busy %b ready %b result %h expected 0 0 0", busy, ready, result);
        end
        @(negedge clk);
        run_op(2'b01, 32'd9, 32'd3, 1'b0, "divu_9_3");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
